// File: rtl/sampler_pkg.sv
// Shared definitions for the sampler channel: RLE word layout and run-length limits.
// The DMA and USB readout blocks import this package to split {run, value} words.
package sampler_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } run_state_t;

  // Value occupies the low bits of an RLE word, the run count sits directly above it.
  localparam int RLE_VALUE_LSB = 0;

  function automatic int rle_run_lsb(input int channels);
    return channels;
  endfunction

  // Largest run count a field of run_w bits can hold (run_w up to 31).
  function automatic int unsigned run_max(input int unsigned run_w);
    return (32'd1 << run_w) - 32'd1;
  endfunction

endpackage

// File: rtl/rle_fifo_fwft.sv
// First-word-fall-through FIFO holding encoded RLE words until the reader takes them.
module rle_fifo_fwft #(
  parameter int W  = 32,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] COUNT_FULL = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // Full is judged on the registered count, so a same-cycle pop never makes room for a push.
  assign full    = (count == COUNT_FULL);
  assign valid   = (count != '0);
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  assign dout    = valid ? mem[rd_ptr] : '0;

  // Storage array; no reset needed because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/synch.sv
// Multi-stage flip-flop synchroniser for asynchronous input pins.
module synch #(
  parameter int w = 1,
  parameter int d = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [w-1:0] din,
  output logic [w-1:0] dout
);

  logic [w-1:0] stages [d];

  // Shift the raw pins through d flops; only the last stage is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < d; i++) stages[i] <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < d; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[d-1];

endmodule

// File: rtl/sample_rle_compressor.sv
// Run-length compressor for the logic-analyser sampler: synchronise, mask, encode into a FIFO.
module sample_rle_compressor #(
  parameter int CHANNELS    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int RUN_W       = 16,
  parameter int FIFO_AW     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       s_in,
  input  logic [CHANNELS-1:0]       chan_mask,
  input  logic                      enable,
  input  logic                      flush,
  output logic [RUN_W+CHANNELS-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      overflow_error,
  input  logic                      clear_error,
  output logic                      busy
);

  import sampler_pkg::*;

  localparam int WORD_W = RUN_W + CHANNELS;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(run_max(RUN_W));

  run_state_t          state;
  logic [CHANNELS-1:0] s_sync;
  logic [CHANNELS-1:0] m;
  logic [CHANNELS-1:0] cur;
  logic [RUN_W-1:0]    run;
  logic                push;
  logic                fifo_full;
  logic [WORD_W-1:0]   push_word;

  synch #(
    .w(CHANNELS),
    .d(SYNC_STAGES)
  ) u_synch (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (s_in),
    .dout (s_sync)
  );

  assign m         = s_sync & chan_mask;
  assign push_word = {run, cur};

  // Any event that closes the open run emits the word describing it.
  assign push = (state == ST_RUN) &&
                (!enable || flush || (m != cur) || (run == RUN_MAX));

  // Run tracker: open a run on enable, extend it while the sample holds, restart on each emitted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cur   <= '0;
      run   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            cur   <= m;
            run   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (flush || (m != cur)) begin
            cur <= m;
            run <= '0;
          end else if (run == RUN_MAX) begin
            run <= '0;
          end else begin
            run <= run + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rle_fifo_fwft #(
    .W (WORD_W),
    .AW(FIFO_AW)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  (push_word),
    .full (fifo_full),
    .pop  (out_ready),
    .dout (out_data),
    .valid(out_valid)
  );

  // Sticky drop indicator; a new drop beats a simultaneous clear so no loss goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_error <= 1'b0;
    end else if (push && fifo_full) begin
      overflow_error <= 1'b1;
    end else if (clear_error) begin
      overflow_error <= 1'b0;
    end
  end

  assign busy = (state == ST_RUN) || out_valid;

endmodule

// File: tb/tb_sample_rle_compressor.sv
// Self-checking bench for sample_rle_compressor: directed scenarios plus a randomized run
// checked against a run-length reference model.
module tb_sample_rle_compressor;

  localparam int CH        = 16;
  localparam int SS        = 2;
  localparam int RW        = 4;
  localparam int AW        = 4;
  localparam int WW        = RW + CH;
  localparam int DEPTH     = 1 << AW;
  localparam int RUN_LIMIT = 1 << RW;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] s_in;
  logic [CH-1:0] chan_mask;
  logic          enable;
  logic          flush;
  logic [WW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          overflow_error;
  logic          clear_error;
  logic          busy;

  int n_compared;
  int n_mismatched;

  // Reference model state: sample history, open run as (value, length in cycles), FIFO contents.
  logic [CH-1:0] hist[$];
  logic [WW-1:0] mq[$];
  bit            m_running;
  logic [CH-1:0] m_cur;
  int            m_len;
  bit            m_ovf;

  sample_rle_compressor #(
    .CHANNELS   (CH),
    .SYNC_STAGES(SS),
    .RUN_W      (RW),
    .FIFO_AW    (AW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_in          (s_in),
    .chan_mask     (chan_mask),
    .enable        (enable),
    .flush         (flush),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overflow_error(overflow_error),
    .clear_error   (clear_error),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    hist.delete();
    mq.delete();
    for (int i = 0; i < SS; i++) hist.push_back('0);
    m_running = 0;
    m_cur     = '0;
    m_len     = 0;
    m_ovf     = 0;
  endtask

  task automatic model_edge();
    logic [CH-1:0] m;
    logic [WW-1:0] word;
    bit            emit;
    bit            full_pre;
    bit            ovf_set;
    m = hist[0] & chan_mask;
    hist.push_back(s_in);
    void'(hist.pop_front());
    emit = 0;
    word = '0;
    if (m_running) begin
      if (!enable) begin
        emit = 1; word = {RW'(m_len - 1), m_cur};
        m_running = 0;
      end else if (flush || m != m_cur) begin
        emit = 1; word = {RW'(m_len - 1), m_cur};
        m_cur = m; m_len = 1;
      end else if (m_len == RUN_LIMIT) begin
        emit = 1; word = {RW'(m_len - 1), m_cur};
        m_len = 1;
      end else begin
        m_len++;
      end
    end else if (enable) begin
      m_running = 1; m_cur = m; m_len = 1;
    end
    full_pre = (mq.size() == DEPTH);
    if (mq.size() > 0 && out_ready) void'(mq.pop_front());
    ovf_set = 0;
    if (emit) begin
      if (full_pre) ovf_set = 1;
      else mq.push_back(word);
    end
    if (ovf_set) m_ovf = 1;
    else if (clear_error) m_ovf = 0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_clear();
      else model_edge();
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    s_in        = '0;
    chan_mask   = '1;
    enable      = 1'b0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    clear_error = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    s_in        = 16'hFFFF;
    chan_mask   = '1;
    enable      = 1'b1;
    flush       = 1'b0;
    out_ready   = 1'b0;
    clear_error = 1'b0;
    step();
    step();
    n_compared++;
    if (out_valid !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid);
    end
    n_compared++;
    if (out_data !== '0) begin
      n_mismatched++; $display("[TB] FAIL reset_data: got %h want 0", out_data);
    end
    n_compared++;
    if (overflow_error !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_ovf: got %b want 0", overflow_error);
    end
    n_compared++;
    if (busy !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_single_run();
    do_reset();
    for (int i = 0; i < 13; i++) begin
      s_in   = 16'h00A5;
      enable = (i >= 2 && i <= 11);
      step();
      if (i == 11) begin
        n_compared++;
        if (out_valid !== 1'b0) begin
          n_mismatched++; $display("[TB] FAIL run_early_valid: got %b want 0", out_valid);
        end
      end
    end
    enable = 1'b0;
    n_compared++;
    if (out_valid !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL run_valid: got %b want 1", out_valid);
    end
    n_compared++;
    if (out_data !== {4'd9, 16'h00A5}) begin
      n_mismatched++; $display("[TB] FAIL run_word: got %h want %h", out_data, {4'd9, 16'h00A5});
    end
    n_compared++;
    if (busy !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL run_busy: got %b want 1", busy);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_compared++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL run_drained: got valid=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_toggle();
    logic [WW-1:0] exp;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      s_in   = (i % 2 == 1) ? 16'hFFFF : 16'h0000;
      enable = (i >= 2 && i <= 5);
      step();
    end
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp = {4'd0, (k % 2 == 1) ? 16'hFFFF : 16'h0000};
      n_compared++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL toggle_word%0d: got valid=%b data=%h want 1 %h", k, out_valid, out_data, exp);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    n_compared++;
    if (out_valid !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL toggle_extra: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 23; i++) begin
      s_in   = 16'hBEEF;
      enable = (i >= 2 && i <= 21);
      step();
      if (i == 18) begin
        n_compared++;
        if (out_valid !== 1'b1 || out_data !== {4'd15, 16'hBEEF}) begin
          n_mismatched++;
          $display("[TB] FAIL sat_split: got valid=%b data=%h want 1 %h", out_valid, out_data, {4'd15, 16'hBEEF});
        end
      end
    end
    enable = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_compared++;
    if (out_valid !== 1'b1 || out_data !== {4'd3, 16'hBEEF}) begin
      n_mismatched++;
      $display("[TB] FAIL sat_tail: got valid=%b data=%h want 1 %h", out_valid, out_data, {4'd3, 16'hBEEF});
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      s_in   = 16'h1000 + 16'(i);
      enable = (i >= 2 && i < 19);
      step();
      if (i == 18) begin
        n_compared++;
        if (overflow_error !== 1'b0) begin
          n_mismatched++; $display("[TB] FAIL ovf_early: got %b want 0", overflow_error);
        end
      end
    end
    enable = 1'b0;
    n_compared++;
    if (overflow_error !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL ovf_set: got %b want 1", overflow_error);
    end
    step();
    n_compared++;
    if (overflow_error !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL ovf_sticky: got %b want 1", overflow_error);
    end
    clear_error = 1'b1;
    step();
    clear_error = 1'b0;
    n_compared++;
    if (overflow_error !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL ovf_clear: got %b want 0", overflow_error);
    end
  endtask

  task automatic test_overflow_clear_same_cycle();
    logic [WW-1:0] exp;
    enable = 1'b1;
    step();
    enable      = 1'b0;
    clear_error = 1'b1;
    step();
    clear_error = 1'b0;
    n_compared++;
    if (overflow_error !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL ovf_set_wins: got %b want 1", overflow_error);
    end
    for (int k = 0; k < DEPTH; k++) begin
      exp = {4'd0, 16'h1000 + 16'(k)};
      n_compared++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL ovf_drain%0d: got valid=%b data=%h want 1 %h", k, out_valid, out_data, exp);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    n_compared++;
    if (out_valid !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL ovf_drained: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_mask_flush();
    do_reset();
    chan_mask = 16'h00FF;
    for (int i = 0; i < 12; i++) begin
      s_in   = {8'($urandom), 8'h5A};
      enable = (i >= 2 && i < 11);
      flush  = (i == 10);
      step();
      if (i == 9) begin
        n_compared++;
        if (out_valid !== 1'b0) begin
          n_mismatched++; $display("[TB] FAIL mask_no_word: got valid=%b want 0", out_valid);
        end
      end
      if (i == 10) begin
        n_compared++;
        if (out_valid !== 1'b1 || out_data !== {4'd7, 16'h005A}) begin
          n_mismatched++;
          $display("[TB] FAIL mask_flush: got valid=%b data=%h want 1 %h", out_valid, out_data, {4'd7, 16'h005A});
        end
      end
    end
    enable = 1'b0;
    flush  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_compared++;
    if (out_valid !== 1'b1 || out_data !== {4'd0, 16'h005A}) begin
      n_mismatched++;
      $display("[TB] FAIL mask_tail: got valid=%b data=%h want 1 %h", out_valid, out_data, {4'd0, 16'h005A});
    end
    chan_mask = '1;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      s_in   = (i % 2 == 1) ? 16'hFFFF : 16'h0000;
      enable = 1'b1;
      step();
    end
    n_compared++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL midrst_pre: got valid=%b busy=%b want 1 1", out_valid, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_compared++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || overflow_error !== 1'b0 || out_data !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL midrst_now: got valid=%b busy=%b ovf=%b data=%h want 0 0 0 0",
               out_valid, busy, overflow_error, out_data);
    end
    step();
    n_compared++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL midrst_next: got valid=%b busy=%b want 0 0", out_valid, busy);
    end
    enable = 1'b0;
    rst_n  = 1'b1;
    step();
  endtask

  task automatic test_random();
    int change_pct;
    int ready_pct;
    do_reset();
    for (int c = 0; c < 900; c++) begin
      change_pct = ((c / 150) % 2 == 0) ? 5 : 50;
      ready_pct  = ((c / 150) % 3 == 1) ? 10 : 60;
      if ($urandom_range(0, 99) < change_pct) s_in = CH'($urandom_range(0, 3) * 16'h1111);
      if ($urandom_range(0, 79) == 0) chan_mask = ($urandom_range(0, 1) == 0) ? '1 : CH'($urandom);
      enable      = ($urandom_range(0, 29) != 0);
      flush       = ($urandom_range(0, 24) == 0);
      out_ready   = ($urandom_range(0, 99) < ready_pct);
      clear_error = ($urandom_range(0, 39) == 0);
      step();
      n_compared++;
      if (out_valid !== (mq.size() > 0)) begin
        n_mismatched++; $display("[TB] FAIL rnd_valid c=%0d: got %b want %b", c, out_valid, mq.size() > 0);
      end
      if (mq.size() > 0) begin
        n_compared++;
        if (out_data !== mq[0]) begin
          n_mismatched++; $display("[TB] FAIL rnd_data c=%0d: got %h want %h", c, out_data, mq[0]);
        end
      end
      n_compared++;
      if (overflow_error !== m_ovf) begin
        n_mismatched++; $display("[TB] FAIL rnd_ovf c=%0d: got %b want %b", c, overflow_error, m_ovf);
      end
      n_compared++;
      if (busy !== (m_running || mq.size() > 0)) begin
        n_mismatched++;
        $display("[TB] FAIL rnd_busy c=%0d: got %b want %b", c, busy, m_running || mq.size() > 0);
      end
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n        = 1'b0;
    test_reset();
    test_single_run();
    test_toggle();
    test_saturation();
    test_overflow();
    test_overflow_clear_same_cycle();
    test_mask_flush();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
